// File: rtl/test_status_monitor_pkg.sv
// Shared types and constants for the ISA compliance status monitor.
package test_status_monitor_pkg;

   // Monitor state encoding, also driven out on o_state
   typedef enum logic [2:0] {
      TS_IDLE    = 3'd0,
      TS_RUN     = 3'd1,
      TS_PASS    = 3'd2,
      TS_FAIL    = 3'd3,
      TS_TIMEOUT = 3'd4
   } test_status_t;

   // Plain constants of the same encoding for the FSM register
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RUN     = 3'd1;
   localparam logic [2:0] S_PASS    = 3'd2;
   localparam logic [2:0] S_FAIL    = 3'd3;
   localparam logic [2:0] S_TIMEOUT = 3'd4;

   // Default signature values written to the status register
   localparam logic [31:0] DEFAULT_PASS_VALUE = 32'hfffffbd2;
   localparam logic [31:0] DEFAULT_FAIL_VALUE = 32'hfffffae5;

endpackage

// File: rtl/test_status_monitor_retire_lane_select.sv
// Youngest-hit finder: among the retire lanes writing the signature register,
// returns the data of the highest-index (youngest) lane.
module test_status_monitor_retire_lane_select #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned NUM_RETIRE     = 1,
   parameter int unsigned SIG_REG        = 3
) (
   input  logic [NUM_RETIRE-1:0]                i_retire_en,
   input  logic [NUM_RETIRE*REG_ADDR_WIDTH-1:0] i_retire_rdest,
   input  logic [NUM_RETIRE*DATA_WIDTH-1:0]     i_retire_data,
   output logic                                 o_hit,
   output logic [DATA_WIDTH-1:0]                o_data
);

   // Later lanes overwrite earlier ones so the youngest hit wins; x0 never hits
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      for (int i = 0; i < int'(NUM_RETIRE); i++) begin
         logic [REG_ADDR_WIDTH-1:0] w_rd;
         w_rd = i_retire_rdest[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         if (i_retire_en[i] && (w_rd == REG_ADDR_WIDTH'(SIG_REG)) && (w_rd != '0)) begin
            o_hit  = 1'b1;
            o_data = i_retire_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/test_status_monitor.sv
// Pass/fail/timeout checker for ISA compliance runs. Snoops committed register
// writes, decides the verdict from a signature register and runs a total-cycle
// and a no-retire watchdog. Verdicts are sticky until reset.
// Build option: TEST_STATUS_GP_ENCODING_EN selects riscv-tests tohost decoding
// (1 = pass, odd = fail with code data>>1, even ignored) instead of the exact
// PASS_VALUE/FAIL_VALUE compare.
module test_status_monitor
   import test_status_monitor_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           REG_ADDR_WIDTH = 5,
   parameter int unsigned           NUM_RETIRE     = 1,
   parameter int unsigned           SIG_REG        = 3,
   parameter logic [DATA_WIDTH-1:0] PASS_VALUE     = DATA_WIDTH'(DEFAULT_PASS_VALUE),
   parameter logic [DATA_WIDTH-1:0] FAIL_VALUE     = DATA_WIDTH'(DEFAULT_FAIL_VALUE),
   parameter int unsigned           CNT_WIDTH      = 32,
   parameter int unsigned           MAX_CYCLES     = 100000,
   parameter int unsigned           STALL_LIMIT    = 1024
) (
   input  logic                                 clk,
   input  logic                                 n_rst,
   input  logic                                 i_start,
   input  logic [NUM_RETIRE-1:0]                i_retire_en,
   input  logic [NUM_RETIRE*REG_ADDR_WIDTH-1:0] i_retire_rdest,
   input  logic [NUM_RETIRE*DATA_WIDTH-1:0]     i_retire_data,
   output logic [2:0]                           o_state,
   output logic                                 o_done,
   output logic                                 o_pass,
   output logic                                 o_fail,
   output logic                                 o_timeout,
   output logic [DATA_WIDTH-1:0]                o_fail_code,
   output logic [CNT_WIDTH-1:0]                 o_cycle_count,
   output logic [CNT_WIDTH-1:0]                 o_retire_count
);

   logic [2:0]            r_state;
   logic [2:0]            w_state_next;
   logic [CNT_WIDTH-1:0]  r_cycle_count;
   logic [CNT_WIDTH-1:0]  r_retire_count;
   logic [CNT_WIDTH-1:0]  r_stall_count;
   logic [DATA_WIDTH-1:0] r_fail_code;

   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_sig_data;
   logic                  w_sig_pass;
   logic                  w_sig_fail;
   logic [DATA_WIDTH-1:0] w_fail_code;
   logic                  w_in_run;
   logic                  w_any_retire;
   logic                  w_timeout;
   logic [CNT_WIDTH-1:0]  w_retire_inc;
   logic [CNT_WIDTH:0]    w_retire_sum;

   test_status_monitor_retire_lane_select #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_RETIRE     (NUM_RETIRE),
      .SIG_REG        (SIG_REG)
   ) u_lane_select (
      .i_retire_en    (i_retire_en),
      .i_retire_rdest (i_retire_rdest),
      .i_retire_data  (i_retire_data),
      .o_hit          (w_hit),
      .o_data         (w_sig_data)
   );

`ifdef TEST_STATUS_GP_ENCODING_EN
   assign w_sig_pass  = w_hit && (w_sig_data == DATA_WIDTH'(1));
   assign w_sig_fail  = w_hit && w_sig_data[0] && (w_sig_data != DATA_WIDTH'(1));
   assign w_fail_code = w_sig_data >> 1;
`else
   assign w_sig_pass  = w_hit && (w_sig_data == PASS_VALUE);
   assign w_sig_fail  = w_hit && (w_sig_data == FAIL_VALUE);
   assign w_fail_code = w_sig_data;
`endif

   assign w_in_run     = (r_state == S_RUN);
   assign w_any_retire = |i_retire_en;
   assign w_timeout    = (!w_any_retire && (r_stall_count == CNT_WIDTH'(STALL_LIMIT - 1)))
                       || (r_cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));

   // Number of lanes retiring this cycle
   always_comb begin
      w_retire_inc = '0;
      for (int i = 0; i < int'(NUM_RETIRE); i++) begin
         w_retire_inc = w_retire_inc + CNT_WIDTH'(i_retire_en[i]);
      end
   end

   assign w_retire_sum = {1'b0, r_retire_count} + {1'b0, w_retire_inc};

   // Next state: fail beats pass, any signature verdict beats timeout
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_sig_fail)      w_state_next = S_FAIL;
            else if (w_sig_pass) w_state_next = S_PASS;
            else if (w_timeout)  w_state_next = S_TIMEOUT;
         end
         default: w_state_next = r_state;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Saturating cycle/retire/stall counters, active only in RUN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cycle_count  <= '0;
         r_retire_count <= '0;
         r_stall_count  <= '0;
      end else if (w_in_run) begin
         if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
         r_retire_count <= w_retire_sum[CNT_WIDTH] ? '1 : w_retire_sum[CNT_WIDTH-1:0];
         if (w_any_retire)             r_stall_count <= '0;
         else if (r_stall_count != '1) r_stall_count <= r_stall_count + 1'b1;
      end
   end

   // Fail code captured on the same edge as the FAIL transition
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                      r_fail_code <= '0;
      else if (w_in_run && w_sig_fail) r_fail_code <= w_fail_code;
   end

   assign o_state        = r_state;
   assign o_pass         = (r_state == S_PASS);
   assign o_fail         = (r_state == S_FAIL);
   assign o_timeout      = (r_state == S_TIMEOUT);
   assign o_done         = o_pass | o_fail | o_timeout;
   assign o_fail_code    = r_fail_code;
   assign o_cycle_count  = r_cycle_count;
   assign o_retire_count = r_retire_count;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor (two retire lanes, short watchdogs).
module tb_test_status_monitor;

   localparam int unsigned NR = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 32;

`ifdef TEST_STATUS_GP_ENCODING_EN
   localparam logic [31:0] PASS_D    = 32'd1;
   localparam logic [31:0] FAIL_D    = 32'd7;
   localparam logic [31:0] FAIL_CODE = 32'd3;
`else
   localparam logic [31:0] PASS_D    = 32'hfffffbd2;
   localparam logic [31:0] FAIL_D    = 32'hfffffae5;
   localparam logic [31:0] FAIL_CODE = 32'hfffffae5;
`endif
   localparam logic [31:0] NEUTRAL_D = 32'd4;

   logic             clk = 1'b0;
   logic             n_rst;
   logic             i_start;
   logic [NR-1:0]    i_retire_en;
   logic [NR*AW-1:0] i_retire_rdest;
   logic [NR*DW-1:0] i_retire_data;
   logic [2:0]       o_state;
   logic             o_done, o_pass, o_fail, o_timeout;
   logic [DW-1:0]    o_fail_code;
   logic [CW-1:0]    o_cycle_count, o_retire_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   test_status_monitor #(
      .DATA_WIDTH     (DW),
      .REG_ADDR_WIDTH (AW),
      .NUM_RETIRE     (NR),
      .SIG_REG        (3),
      .CNT_WIDTH      (CW),
      .MAX_CYCLES     (64),
      .STALL_LIMIT    (16)
   ) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .i_start        (i_start),
      .i_retire_en    (i_retire_en),
      .i_retire_rdest (i_retire_rdest),
      .i_retire_data  (i_retire_data),
      .o_state        (o_state),
      .o_done         (o_done),
      .o_pass         (o_pass),
      .o_fail         (o_fail),
      .o_timeout      (o_timeout),
      .o_fail_code    (o_fail_code),
      .o_cycle_count  (o_cycle_count),
      .o_retire_count (o_retire_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      else             n_pass++;
   endtask

   task automatic do_reset();
      n_rst          = 1'b0;
      i_start        = 1'b0;
      i_retire_en    = '0;
      i_retire_rdest = '0;
      i_retire_data  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic start_run();
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   // One clock with the given lanes; outputs are settled on return
   task automatic tick(input logic [1:0] en, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic [4:0] rd0, input logic [31:0] d0);
      i_retire_en    = en;
      i_retire_rdest = {rd1, rd0};
      i_retire_data  = {d1, d0};
      @(posedge clk);
      #1;
      i_retire_en    = '0;
      i_retire_rdest = '0;
      i_retire_data  = '0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_state", 64'(o_state), 64'd0);
      check_eq("rst_done", 64'(o_done), 64'd0);
      check_eq("rst_cycles", 64'(o_cycle_count), 64'd0);
      check_eq("rst_retires", 64'(o_retire_count), 64'd0);
      check_eq("rst_code", 64'(o_fail_code), 64'd0);

      // Retires ignored in IDLE
      tick(2'b01, 5'd0, 32'd0, 5'd3, PASS_D);
      check_eq("idle_state", 64'(o_state), 64'd0);
      check_eq("idle_retires", 64'(o_retire_count), 64'd0);

      // Pass after 10 ordinary retires
      start_run();
      check_eq("pass_run", 64'(o_state), 64'd1);
      for (int i = 0; i < 10; i++) tick(2'b01, 5'd0, 32'd0, 5'd1, 32'(i));
      check_eq("pass_pre", 64'(o_pass), 64'd0);
      check_eq("pass_pre_ret", 64'(o_retire_count), 64'd10);
      tick(2'b01, 5'd0, 32'd0, 5'd3, PASS_D);
      check_eq("pass_flag", 64'(o_pass), 64'd1);
      check_eq("pass_done", 64'(o_done), 64'd1);
      check_eq("pass_state", 64'(o_state), 64'd2);
      check_eq("pass_onehot", 64'({o_fail, o_timeout}), 64'd0);
      check_eq("pass_ret", 64'(o_retire_count), 64'd11);
      check_eq("pass_cyc", 64'(o_cycle_count), 64'd11);
      start_run();
      tick(2'b01, 5'd0, 32'd0, 5'd3, FAIL_D);
      check_eq("pass_sticky", 64'(o_state), 64'd2);
      check_eq("pass_frz_cyc", 64'(o_cycle_count), 64'd11);
      check_eq("pass_frz_ret", 64'(o_retire_count), 64'd11);

      // Fail, then later pass write ignored
      do_reset();
      start_run();
      tick(2'b01, 5'd0, 32'd0, 5'd3, NEUTRAL_D);
      check_eq("neutral_run", 64'(o_state), 64'd1);
      tick(2'b01, 5'd0, 32'd0, 5'd2, PASS_D);
      check_eq("other_reg_run", 64'(o_state), 64'd1);
      tick(2'b01, 5'd0, 32'd0, 5'd3, FAIL_D);
      check_eq("fail_flag", 64'(o_fail), 64'd1);
      check_eq("fail_code", 64'(o_fail_code), 64'(FAIL_CODE));
      check_eq("fail_pass0", 64'(o_pass), 64'd0);
      tick(2'b01, 5'd0, 32'd0, 5'd3, PASS_D);
      check_eq("fail_sticky", 64'(o_state), 64'd3);
      check_eq("fail_code_hold", 64'(o_fail_code), 64'(FAIL_CODE));
      check_eq("fail_ret", 64'(o_retire_count), 64'd3);

      // Two lanes: youngest hit decides
      do_reset();
      start_run();
      tick(2'b11, 5'd3, FAIL_D, 5'd3, PASS_D);
      check_eq("ml_fail_state", 64'(o_state), 64'd3);
      check_eq("ml_fail_ret", 64'(o_retire_count), 64'd2);
      do_reset();
      start_run();
      tick(2'b11, 5'd3, PASS_D, 5'd3, FAIL_D);
      check_eq("ml_pass_state", 64'(o_state), 64'd2);
      check_eq("ml_pass_code", 64'(o_fail_code), 64'd0);
      do_reset();
      start_run();
      tick(2'b11, 5'd3, NEUTRAL_D, 5'd3, PASS_D);
      check_eq("ml_young_neutral", 64'(o_state), 64'd1);

      // Stall watchdog: timeout after 16 idle RUN cycles
      do_reset();
      start_run();
      repeat (15) tick(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      check_eq("stall_pre", 64'(o_timeout), 64'd0);
      tick(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      check_eq("stall_to", 64'(o_timeout), 64'd1);
      check_eq("stall_state", 64'(o_state), 64'd4);
      check_eq("stall_done", 64'(o_done), 64'd1);
      check_eq("stall_cyc", 64'(o_cycle_count), 64'd16);
      repeat (3) tick(2'b01, 5'd0, 32'd0, 5'd1, 32'd0);
      check_eq("stall_frz_cyc", 64'(o_cycle_count), 64'd16);
      check_eq("stall_frz_ret", 64'(o_retire_count), 64'd0);

      // Total-cycle watchdog
      do_reset();
      start_run();
      repeat (63) tick(2'b01, 5'd0, 32'd0, 5'd1, 32'd0);
      check_eq("max_pre", 64'(o_state), 64'd1);
      tick(2'b01, 5'd0, 32'd0, 5'd1, 32'd0);
      check_eq("max_to", 64'(o_timeout), 64'd1);
      check_eq("max_cyc", 64'(o_cycle_count), 64'd64);
      check_eq("max_ret", 64'(o_retire_count), 64'd64);

      // Signature hit beats a same-cycle timeout
      do_reset();
      start_run();
      repeat (63) tick(2'b01, 5'd0, 32'd0, 5'd1, 32'd0);
      tick(2'b01, 5'd0, 32'd0, 5'd3, PASS_D);
      check_eq("hit_beats_to", 64'(o_state), 64'd2);

      // Asynchronous reset mid-run
      do_reset();
      start_run();
      repeat (50) tick(2'b01, 5'd0, 32'd0, 5'd1, 32'd0);
      check_eq("mid_cyc", 64'(o_cycle_count), 64'd50);
      #1 n_rst = 1'b0;
      #1;
      check_eq("arst_state", 64'(o_state), 64'd0);
      check_eq("arst_cyc", 64'(o_cycle_count), 64'd0);
      check_eq("arst_ret", 64'(o_retire_count), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      tick(2'b01, 5'd0, 32'd0, 5'd3, PASS_D);
      check_eq("arst_idle", 64'(o_state), 64'd0);
      check_eq("arst_nopass", 64'(o_pass), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Synthesizable pass/fail/timeout checker for ISA compliance runs; generalizes the hard-wired "watch x3 for magic value" check into a reusable block.
- Snoops up to NUM_RETIRE committed register writes per cycle from the reorder buffer's regmap destination-write path.
- Decides PASS/FAIL from a configurable signature register and runs two watchdogs: total cycles and cycles without retirement.
- Sits beside register_map in every core-level bench; outputs feed bench $stop logic or an FPGA status LED/UART.

Parameters:
- DATA_WIDTH, 32, retired data width
- REG_ADDR_WIDTH, 5, architectural register index width
- NUM_RETIRE, 1, retire lanes observed per cycle (1..4)
- SIG_REG, 3, architectural register carrying test status
- PASS_VALUE, 32'hfffffbd2, signature value meaning pass (exact-compare mode)
- FAIL_VALUE, 32'hfffffae5, signature value meaning fail (exact-compare mode)
- CNT_WIDTH, 32, width of cycle/retire counters
- MAX_CYCLES, 100000, total-cycle limit in RUN
- STALL_LIMIT, 1024, consecutive cycles with no retire before timeout

Ports:
- clk, input, 1, clock
- n_rst, input, 1, asynchronous active-low reset
- i_start, input, 1, pulse: IDLE->RUN
- i_retire_en, input, NUM_RETIRE, lane valid; lane 0 is oldest
- i_retire_rdest, input, NUM_RETIRE*REG_ADDR_WIDTH, packed destination register per lane
- i_retire_data, input, NUM_RETIRE*DATA_WIDTH, packed committed data per lane
- o_state, output, 3, encoded FSM state (test_status_t)
- o_done, output, 1, terminal state reached
- o_pass, output, 1, PASS reached
- o_fail, output, 1, FAIL reached
- o_timeout, output, 1, either watchdog fired
- o_fail_code, output, DATA_WIDTH, signature value that caused FAIL
- o_cycle_count, output, CNT_WIDTH, cycles spent in RUN
- o_retire_count, output, CNT_WIDTH, instructions retired in RUN

Behaviour:
- Reset: state IDLE; all outputs and counters 0. Reset mid-run aborts immediately with no residual status.
- States:
  - IDLE: retires ignored; i_start -> RUN.
  - RUN -> PASS, FAIL, or TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset; i_start is ignored outside IDLE.
- Lane selection: a lane hits when en=1 and rdest==SIG_REG. With several hits in one cycle, the highest-index (youngest) lane's data is evaluated. Writes to x0 are never a hit, even if SIG_REG=0.
- Compare (exact mode): data==FAIL_VALUE -> FAIL; data==PASS_VALUE -> PASS; any other value leaves the FSM in RUN. If the two values are equal, FAIL wins.
- Latency: status outputs are registered and assert on the cycle after the retire edge. o_fail_code is captured in the same edge as the FAIL transition.
- Counters (RUN only):
  - o_cycle_count increments every cycle.
  - o_retire_count adds popcount(i_retire_en), including the cycle that terminates.
  - Both saturate at all-ones and freeze in terminal states.
- Watchdogs:
  - Internal stall counter resets on any retire, otherwise increments.
  - stall==STALL_LIMIT-1 with no retire, or cycle_count==MAX_CYCLES-1, -> TIMEOUT on the next edge.
  - A signature hit in the same cycle beats timeout.
- Derived outputs: o_done = PASS|FAIL|TIMEOUT. o_pass, o_fail and o_timeout are one-hot or all zero.

Optional Feature:
- Macro: TEST_STATUS_GP_ENCODING_EN.
- Defined: riscv-tests tohost encoding replaces the exact compare.
  - Signature data==1 -> PASS.
  - Odd data !=1 -> FAIL, with o_fail_code = data>>1 (failing TESTNUM).
  - Even data is ignored.
  - PASS_VALUE and FAIL_VALUE are unused.
- Undefined: exact compare against PASS_VALUE/FAIL_VALUE as above.

Decomposition:
- Package types gains:
  - test_status_t enum: IDLE, RUN, PASS, FAIL, TIMEOUT.
  - Default PASS/FAIL signature constants.
- One natural sub-module, retire_lane_select: combinational youngest-hit finder across NUM_RETIRE lanes, returning hit and data.
- Counters and FSM stay in test_status_monitor.

Test Plan:
- Pass: i_start, retire x3=32'hfffffbd2 after 10 single retires -> o_pass=1 next cycle, o_retire_count=11, o_done=1.
- Fail: retire x3=32'hfffffae5 -> o_fail=1, o_fail_code=32'hfffffae5; a later PASS write is ignored.
- Multi-lane: NUM_RETIRE=2, lane0 x3=PASS_VALUE and lane1 x3=FAIL_VALUE in the same cycle -> FAIL. Swapped lanes -> PASS.
- Stall: STALL_LIMIT=16, no retires after start -> o_timeout=1 at cycle 16; counters freeze.
- Reset: n_rst pulsed while in RUN at cycle 50 -> all outputs 0 asynchronously, state IDLE; retire of PASS_VALUE without i_start -> no change.
- Macro on: x3=1 -> PASS; x3=7 -> FAIL with o_fail_code=3; x3=4 -> stays RUN.
